weights_fetch_sequencer: RTL
============================

Name: weights_fetch_sequencer

Overview:
Sequences reads of the 20x20 weight register file: it generates row/col addresses in raster order and absorbs the file's 1-cycle registered read latency. It streams each weight with its coordinates to the downstream MAC array over a valid/ready handshake. A credit-limited 2-entry buffer gives full throughput without losing data under backpressure. It sits between the layer controller (start/abort/done) and the MAC datapath.

Parameters:
ROWS, 20, matrix rows fetched per run
COLS, 20, matrix columns fetched per run
DATA_W, 32, weight word width
ADDR_W, 5, row/col address width; must satisfy 2^ADDR_W >= max(ROWS, COLS)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to begin a full-matrix fetch; ignored unless IDLE
abort  in  1  cancel the current run; beats priority over start
busy  out  1  high from the cycle after an accepted start until the run ends
done  out  1  one-cycle pulse after the last beat handshakes; never pulses on abort
rf_row_addr  out  ADDR_W  row address to the weight register file
rf_col_addr  out  ADDR_W  column address to the weight register file
rf_data  in  DATA_W  weight register file output, valid 1 cycle after address
w_valid  out  1  weight beat valid
w_ready  in  1  downstream accepts beat
w_data  out  DATA_W  weight value
w_row  out  ADDR_W  row index of beat
w_col  out  ADDR_W  column index of beat
w_last  out  1  beat is element (ROWS-1, COLS-1)

Behaviour:
- Reset: state IDLE. busy, done, w_valid and w_last = 0. rf/w addresses = 0. w_data = 0. FIFO empty. inflight = 0.
- States:
  - IDLE: start (and not abort) -> FETCH. Address counters clear to (0,0).
  - FETCH: issues reads. After issuing (ROWS-1, COLS-1) -> DRAIN.
  - DRAIN: waits for the last beat to handshake -> IDLE. done = 1 in the following cycle.
- Issue rule: in FETCH, a read issues in a cycle when count + inflight - pop < 2, where pop = w_valid & w_ready.
  - On issue: present {row, col} on rf_*_addr. Set inflight = 1 for the next cycle.
  - Column increments and wraps COLS-1 -> 0 with row+1. Out-of-range addresses are never generated.
- Capture: in the cycle after an issue, rf_data is pushed into the FIFO together with its row, col and last tags. The tags are pipelined alongside the address.
- Credit rule: the FIFO can never overflow. Overflow is an assertion failure.
- Output: w_valid = FIFO not empty. The FIFO head is registered.
  - While w_valid & !w_ready, w_data, w_row, w_col and w_last hold stable.
- Latency with w_ready = 1:
  - start sampled at cycle 0.
  - Address (0,0) driven at cycle 1.
  - First w_valid at cycle 3.
  - One beat per cycle after that.
  - Last beat at cycle ROWS*COLS+2 = 402.
  - done pulses at cycle 403.
  - busy falls with done.
- rf addresses hold their last value when not issuing. The file re-reads the same word harmlessly.
- abort (any state):
  - Next state IDLE. FIFO flushed. The in-flight read is discarded and not pushed.
  - w_valid = 0 next cycle. No done.
- start while busy is ignored.
- start and abort in the same IDLE cycle: remain IDLE.
- Reset mid-run: immediate return to reset values. No done.

Decomposition:
- Package kws_weights_pkg:
  - ROWS, COLS, DATA_W, ADDR_W constants.
  - State enum {IDLE, FETCH, DRAIN}.
  - Beat struct {data, row, col, last}.
- Sub-module weights_beat_fifo: 2-entry synchronous FIFO of beat structs with push, pop, flush, count and registered head.
- Sequencer FSM, address counters and credit logic stay in the top module.

Test Plan:
- Full sweep, w_ready = 1, file loaded with W[r][c] = {r,c} pattern:
  - Exactly 400 beats, in raster order.
  - First w_valid at cycle 3; beat k carries (k/20, k%20).
  - w_last only on (19,19); done pulse at cycle 403.
- Random w_ready (~50% duty):
  - All 400 beats arrive, in order, with no duplicates or drops.
  - Beat fields are stable while stalled; FIFO count never exceeds 2.
- w_ready held low 50 cycles from cycle 10:
  - Exactly 2 beats buffered, address issue frozen.
  - On release, the stream resumes at the correct (row,col).
- abort at beat 137:
  - w_valid = 0 the next cycle; busy falls; no done.
  - A new start then restarts from (0,0).
- start pulsed at cycle 50 of a run:
  - Ignored; sequence and done timing identical to the full sweep.
- rst_n asserted mid-DRAIN:
  - All outputs return to reset values asynchronously; no done.
  - A later start yields a full correct sweep.

Source files
------------

// File: rtl/kws_weights_pkg.sv
// Shared constants, FSM state encoding and beat record for the weight fetch path.
// Beats carry the weight word plus its coordinates and an end-of-matrix tag.
package kws_weights_pkg;

   localparam int ROWS   = 20;
   localparam int COLS   = 20;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      logic              last;
   } beat_t;

   function automatic logic is_last_elem(input logic [ADDR_W-1:0] row,
                                         input logic [ADDR_W-1:0] col);
      return (row == ADDR_W'(ROWS - 1)) && (col == ADDR_W'(COLS - 1));
   endfunction

endpackage

// File: rtl/weights_fetch_sequencer_if.sv
// Weight beat stream toward the MAC array: valid/ready with data and coordinates.
// Source holds all payload fields stable while valid is high and ready is low.
interface weights_fetch_sequencer_if;
   import kws_weights_pkg::*;

   logic              w_valid;
   logic              w_ready;
   logic [DATA_W-1:0] w_data;
   logic [ADDR_W-1:0] w_row;
   logic [ADDR_W-1:0] w_col;
   logic              w_last;

   modport master (
      output w_valid,
      output w_data,
      output w_row,
      output w_col,
      output w_last,
      input  w_ready
   );

   modport slave (
      input  w_valid,
      input  w_data,
      input  w_row,
      input  w_col,
      input  w_last,
      output w_ready
   );

endinterface

// File: rtl/weights_beat_fifo.sv
// Two-entry beat FIFO with a registered head slot; push/pop are visible next cycle.
// No internal backpressure: the producer must hold a credit before pushing.
module weights_beat_fifo
   import kws_weights_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  beat_t      din,
   output beat_t      head,
   output logic [1:0] count
);

   beat_t slot1;

   // Head is always slot 0, so the output fields come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head <= din;
               end else begin
                  slot1 <= din;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head  <= slot1;
                  slot1 <= din;
               end else begin
                  head <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && !flush && (count == 2'd2)));

   underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && !flush && (count == 2'd0)));

endmodule

// File: rtl/weights_fetch_sequencer.sv
// Raster-order reader of the weight file; first beat 3 cycles after start, then 1/cycle.
// Reads issue only while FIFO occupancy plus the in-flight read leaves a free slot.
module weights_fetch_sequencer
   import kws_weights_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_row_addr,
   output logic [ADDR_W-1:0] rf_col_addr,
   input  logic [DATA_W-1:0] rf_data,
   weights_fetch_sequencer_if.master w
);

   state_t            state;
   state_t            state_nxt;
   logic              done_nxt;

   logic [ADDR_W-1:0] row_cnt;
   logic [ADDR_W-1:0] col_cnt;
   logic [ADDR_W-1:0] row_q;
   logic [ADDR_W-1:0] col_q;
   logic [ADDR_W-1:0] tag_row;
   logic [ADDR_W-1:0] tag_col;
   logic              tag_last;
   logic              inflight;

   logic              issue;
   logic              issue_last;
   logic              pop;
   logic              push;
   logic [1:0]        count;
   beat_t             head;
   beat_t             din;

   assign pop        = w.w_valid & w.w_ready;
   assign push       = inflight & ~abort;
   assign issue_last = is_last_elem(row_cnt, col_cnt);

   // count + inflight - pop < 2, rearranged to avoid unsigned underflow.
   assign issue = (state == FETCH) && !abort &&
                  (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

   // The file keeps seeing the last issued address while reads are paused.
   assign rf_row_addr = issue ? row_cnt : row_q;
   assign rf_col_addr = issue ? col_cnt : col_q;

   assign din.data = rf_data;
   assign din.row  = tag_row;
   assign din.col  = tag_col;
   assign din.last = tag_last;

   weights_beat_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (abort),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign w.w_valid = (count != 2'd0);
   assign w.w_data  = head.data;
   assign w.w_row   = head.row;
   assign w.w_col   = head.col;
   assign w.w_last  = head.last;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (issue && issue_last) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head.last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (abort) begin
         state_nxt = IDLE;
         done_nxt  = 1'b0;
      end
   end

   // Address counters plus the tag pipeline that rides alongside the 1-cycle read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt  <= '0;
         col_cnt  <= '0;
         row_q    <= '0;
         col_q    <= '0;
         tag_row  <= '0;
         tag_col  <= '0;
         tag_last <= 1'b0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (state == IDLE) begin
            row_cnt <= '0;
            col_cnt <= '0;
         end else if (issue) begin
            row_q    <= row_cnt;
            col_q    <= col_cnt;
            tag_row  <= row_cnt;
            tag_col  <= col_cnt;
            tag_last <= issue_last;
            if (col_cnt == ADDR_W'(COLS - 1)) begin
               col_cnt <= '0;
               row_cnt <= issue_last ? '0 : row_cnt + ADDR_W'(1);
            end else begin
               col_cnt <= col_cnt + ADDR_W'(1);
            end
         end
      end
   end

endmodule
